// File: rtl/conv1_pkg.sv
// Shared conv1 geometry, FSM state encoding and the unsigned max helper
// used by the conv1 pool reader slice.
package conv1_pkg;

    localparam int CONV1_PIX       = 24;
    localparam int CONV1_W         = 8;
    localparam int CONV1_CH        = 4;
    localparam int CONV1_ROWS      = 24;
    localparam int CONV1_HALF      = CONV1_PIX / 2;
    localparam int CONV1_ROW_BITS  = CONV1_PIX * CONV1_W;
    localparam int CONV1_OCH_BITS  = CONV1_HALF * CONV1_W;
    localparam int CONV1_OUT_BITS  = CONV1_CH * CONV1_OCH_BITS;
    localparam int CONV1_CNT_BITS  = 5;
    localparam int CONV1_OROW_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } conv1_state_e;

    function automatic logic [CONV1_W-1:0] max_u(input logic [CONV1_W-1:0] a,
                                                 input logic [CONV1_W-1:0] b);
        logic [CONV1_W-1:0] m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/pool2x2_lane.sv
// One 2x2 pooling lane: unsigned maximum of two buffered and two live pixels.
module pool2x2_lane
    import conv1_pkg::*;
(
    input  logic [CONV1_W-1:0] a_i,
    input  logic [CONV1_W-1:0] b_i,
    input  logic [CONV1_W-1:0] c_i,
    input  logic [CONV1_W-1:0] d_i,
    output logic [CONV1_W-1:0] max_o
);

    logic [CONV1_W-1:0] top_s;
    logic [CONV1_W-1:0] bot_s;

    // Reduce each row pair first, then the two partial maxima.
    always_comb begin
        top_s = max_u(a_i, b_i);
        bot_s = max_u(c_i, d_i);
        max_o = max_u(top_s, bot_s);
    end

endmodule

// File: rtl/conv1_pool_reader.sv
// Read-side consumer of the four conv1 SRAMs: buffers even rows, pools each
// odd row against its partner and holds one pooled row for layer 2.
module conv1_pool_reader
    import conv1_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    input  logic                        in_sof_i,
    input  logic [CONV1_ROW_BITS-1:0]   in_data_0_i,
    input  logic [CONV1_ROW_BITS-1:0]   in_data_1_i,
    input  logic [CONV1_ROW_BITS-1:0]   in_data_2_i,
    input  logic [CONV1_ROW_BITS-1:0]   in_data_3_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [CONV1_OUT_BITS-1:0]   out_data_o,
    output logic [CONV1_OROW_BITS-1:0]  out_row_o,
    output logic                        out_eof_o,
    output logic                        overflow_o
);

    conv1_state_e                state_q;
    logic [CONV1_CNT_BITS-1:0]   row_cnt_q;
    logic [CONV1_CNT_BITS-1:0]   row_cnt_d;
    logic [CONV1_ROW_BITS-1:0]   buf_q [CONV1_CH];
    logic [CONV1_ROW_BITS-1:0]   in_row_s [CONV1_CH];
    logic [CONV1_OUT_BITS-1:0]   pooled_s;
    logic                        out_valid_q;
    logic [CONV1_OUT_BITS-1:0]   out_data_q;
    logic [CONV1_OROW_BITS-1:0]  out_row_q;
    logic [CONV1_OROW_BITS-1:0]  out_row_d;
    logic                        out_eof_q;
    logic                        out_eof_d;
    logic                        overflow_q;
    logic                        load_ok_s;
    logic                        last_row_s;

    assign in_row_s[0] = in_data_0_i;
    assign in_row_s[1] = in_data_1_i;
    assign in_row_s[2] = in_data_2_i;
    assign in_row_s[3] = in_data_3_i;

    for (genvar c = 0; c < CONV1_CH; c++) begin : g_ch
        for (genvar j = 0; j < CONV1_HALF; j++) begin : g_px
            pool2x2_lane u_lane (
                .a_i   (buf_q[c][CONV1_ROW_BITS-1-CONV1_W*(2*j)   -: CONV1_W]),
                .b_i   (buf_q[c][CONV1_ROW_BITS-1-CONV1_W*(2*j+1) -: CONV1_W]),
                .c_i   (in_row_s[c][CONV1_ROW_BITS-1-CONV1_W*(2*j)   -: CONV1_W]),
                .d_i   (in_row_s[c][CONV1_ROW_BITS-1-CONV1_W*(2*j+1) -: CONV1_W]),
                .max_o (pooled_s[(CONV1_CH-c)*CONV1_OCH_BITS-1-CONV1_W*j -: CONV1_W])
            );
        end
    end

    // Next-count, pooled-row index and whether the held word may be replaced.
    always_comb begin
        row_cnt_d  = row_cnt_q + 5'd1;
        out_row_d  = row_cnt_q[CONV1_CNT_BITS-1:1];
        out_eof_d  = (out_row_d == 4'(CONV1_ROWS/2 - 1));
        last_row_s = (row_cnt_d == 5'(CONV1_ROWS));
        load_ok_s  = (!out_valid_q) || out_ready_i;
    end

    // Frame FSM, line buffer and single-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= 5'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {CONV1_OUT_BITS{1'b0}};
            out_row_q   <= 4'd0;
            out_eof_q   <= 1'b0;
            overflow_q  <= 1'b0;
            for (int c = 0; c < CONV1_CH; c++) begin
                buf_q[c] <= {CONV1_ROW_BITS{1'b0}};
            end
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (in_valid_i && in_sof_i) begin
                // Resync: any beat flagged sof becomes row 0, pending output untouched.
                for (int c = 0; c < CONV1_CH; c++) begin
                    buf_q[c] <= in_row_s[c];
                end
                row_cnt_q  <= 5'd1;
                state_q    <= ODD;
                overflow_q <= 1'b0;
            end else if (in_valid_i) begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    EVEN: begin
                        for (int c = 0; c < CONV1_CH; c++) begin
                            buf_q[c] <= in_row_s[c];
                        end
                        row_cnt_q <= row_cnt_d;
                        state_q   <= ODD;
                    end
                    ODD: begin
                        if (load_ok_s) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= pooled_s;
                            out_row_q   <= out_row_d;
                            out_eof_q   <= out_eof_d;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        if (last_row_s) begin
                            row_cnt_q <= 5'd0;
                            state_q   <= IDLE;
                        end else begin
                            row_cnt_q <= row_cnt_d;
                            state_q   <= EVEN;
                        end
                    end
                    default: begin
                        row_cnt_q <= 5'd0;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign out_eof_o   = out_eof_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_conv1_pool_reader.sv
// Self-checking bench for conv1_pool_reader: a pooling vector table plus
// hand-written frame, overflow, reload, resync and reset sequences.
module tb_conv1_pool_reader;
    import conv1_pkg::*;

    typedef logic [CONV1_OUT_BITS-1:0] word_t;
    typedef logic [CONV1_ROW_BITS-1:0] row_t;
    typedef struct {
        word_t      data;
        logic [3:0] row;
        logic       eof;
    } exp_t;
    typedef struct {
        int         ch;
        int         j;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    row_t       in_d [CONV1_CH];
    logic       out_ready;
    logic       out_valid;
    word_t      out_data;
    logic [3:0] out_row;
    logic       out_eof;
    logic       overflow;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conv1_pool_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_sof_i    (in_sof),
        .in_data_0_i (in_d[0]),
        .in_data_1_i (in_d[1]),
        .in_data_2_i (in_d[2]),
        .in_data_3_i (in_d[3]),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_row_o   (out_row),
        .out_eof_o   (out_eof),
        .overflow_o  (overflow)
    );

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t fill_row(input logic [7:0] v);
        row_t r;
        for (int i = 0; i < CONV1_PIX; i++) r[CONV1_ROW_BITS-1-8*i -: 8] = v;
        return r;
    endfunction

    function automatic word_t fill_word(input logic [7:0] v);
        word_t w;
        for (int k = 0; k < CONV1_CH*CONV1_HALF; k++) w[CONV1_OUT_BITS-1-8*k -: 8] = v;
        return w;
    endfunction

    function automatic word_t one_pix(input int ch, input int j, input logic [7:0] v);
        word_t w;
        w = '0;
        w[(CONV1_CH-ch)*CONV1_OCH_BITS-1-8*j -: 8] = v;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int c = 0; c < CONV1_CH; c++) in_d[c] = fill_row(v);
    endtask

    task automatic push(input word_t d, input logic [3:0] r, input logic e);
        exp_t x;
        x.data = d;
        x.row  = r;
        x.eof  = e;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d rows still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: every accepted output word is compared against the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: row %0d data %0h, required none", out_row, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_row", word_t'(out_row), word_t'(e.row));
                chk("out_eof", word_t'(out_eof), word_t'(e.eof));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, 0,  8'd10, 8'd200, 8'd250, 8'd3,   8'd250};
        vecs[1] = '{0, 0,  8'd255, 8'd0,  8'd0,   8'd0,   8'd255};
        vecs[2] = '{1, 3,  8'd1,  8'd2,   8'd3,   8'd4,   8'd4};
        vecs[3] = '{3, 11, 8'd7,  8'd128, 8'd127, 8'd9,   8'd128};
        vecs[4] = '{0, 5,  8'd0,  8'd0,   8'd0,   8'd200, 8'd200};
        vecs[5] = '{3, 0,  8'd5,  8'd9,   8'd1,   8'd2,   8'd9};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        out_ready = 1'b0;
        set_all(8'd0);
        repeat (3) tick();
        chk("rst_valid", word_t'(out_valid), word_t'(1'b0));
        chk("rst_data", out_data, '0);
        chk("rst_row", word_t'(out_row), '0);
        chk("rst_eof", word_t'(out_eof), '0);
        chk("rst_overflow", word_t'(overflow), '0);
        rst_n = 1'b1;
        tick();

        // Pooling table: one channel, one pixel pair, two-row frame each.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            set_all(8'd0);
            in_d[vecs[v].ch][CONV1_ROW_BITS-1-8*(2*vecs[v].j)   -: 8] = vecs[v].a;
            in_d[vecs[v].ch][CONV1_ROW_BITS-1-8*(2*vecs[v].j+1) -: 8] = vecs[v].b;
            in_valid = 1'b1;
            in_sof = 1'b1;
            tick();
            set_all(8'd0);
            in_d[vecs[v].ch][CONV1_ROW_BITS-1-8*(2*vecs[v].j)   -: 8] = vecs[v].c;
            in_d[vecs[v].ch][CONV1_ROW_BITS-1-8*(2*vecs[v].j+1) -: 8] = vecs[v].d;
            in_sof = 1'b0;
            push(one_pix(vecs[v].ch, vecs[v].j, vecs[v].e), 4'd0, 1'b0);
            tick();
            in_valid = 1'b0;
            drain("table");
        end

        // Full frame, back-to-back beats, row r filled with r.
        for (int r = 0; r < CONV1_ROWS; r++) begin
            in_valid = 1'b1;
            in_sof = (r == 0);
            set_all(8'(r));
            if (r % 2 == 1) push(fill_word(8'(r)), 4'(r/2), (r == CONV1_ROWS-1));
            tick();
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        drain("frame");

        // Overflow: two pooled rows with the consumer stalled.
        out_ready = 1'b0;
        push(fill_word(8'd2), 4'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_sof = (r == 0);
            set_all(8'(r + 1));
            tick();
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        tick();
        chk("ovf_valid", word_t'(out_valid), word_t'(1'b1));
        chk("ovf_held_data", out_data, fill_word(8'd2));
        chk("ovf_held_row", word_t'(out_row), '0);
        chk("ovf_flag", word_t'(overflow), word_t'(1'b1));
        out_ready = 1'b1;
        tick();
        chk("ovf_sticky", word_t'(overflow), word_t'(1'b1));
        drain("ovf");
        in_valid = 1'b1;
        in_sof = 1'b1;
        set_all(8'd0);
        tick();
        in_valid = 1'b0;
        in_sof = 1'b0;
        chk("ovf_clear_on_sof", word_t'(overflow), '0);

        // Accept and reload in the same cycle.
        out_ready = 1'b0;
        push(fill_word(8'd20), 4'd0, 1'b0);
        push(fill_word(8'd40), 4'd1, 1'b0);
        in_valid = 1'b1;
        in_sof = 1'b1;
        set_all(8'd10);
        tick();
        in_sof = 1'b0;
        set_all(8'd20);
        tick();
        set_all(8'd30);
        tick();
        set_all(8'd40);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain("reload");
        chk("reload_no_overflow", word_t'(overflow), '0);

        // Resync after row 6; orphan row 6 must not reach the new frame.
        for (int r = 0; r < 7; r++) begin
            in_valid = 1'b1;
            in_sof = (r == 0);
            set_all(8'(r));
            if (r % 2 == 1) push(fill_word(8'(r)), 4'(r/2), 1'b0);
            tick();
        end
        in_sof = 1'b1;
        set_all(8'd2);
        tick();
        in_sof = 1'b0;
        set_all(8'd4);
        push(fill_word(8'd4), 4'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        drain("resync");

        // Asynchronous reset while in ODD with a held word.
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1;
            in_sof = (r == 0);
            set_all(8'(r + 5));
            tick();
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        chk("pre_reset_valid", word_t'(out_valid), word_t'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", word_t'(out_valid), '0);
        chk("arst_data", out_data, '0);
        chk("arst_row", word_t'(out_row), '0);
        chk("arst_eof", word_t'(out_eof), '0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_all(8'd9);
        tick();
        set_all(8'd10);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("no_sof_ignored", word_t'(out_valid), '0);
        chk("no_sof_overflow", word_t'(overflow), '0);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
